// File: rtl/spike_aer_arbiter.sv
// Round-robin arbiter serialising neuron spikes onto an AER valid/ready stream.
// Define AER_TIMESTAMP_EN to add a free-running timestamp carried on aer_ts.
module spike_aer_arbiter #(
    parameter int N_NEURONS = 8,
    parameter int ADDR_W    = $clog2(N_NEURONS),
    parameter int TS_W      = 16,
    parameter int DROP_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_NEURONS-1:0] spike_in,
    output logic                 aer_valid,
    input  logic                 aer_ready,
    output logic [ADDR_W-1:0]    aer_addr,
`ifdef AER_TIMESTAMP_EN
    output logic [TS_W-1:0]      aer_ts,
`endif
    output logic                 overflow,
    output logic [DROP_W-1:0]    drop_cnt
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                state;
    state_t                state_nx;
    logic [N_NEURONS-1:0]  pending;
    logic [N_NEURONS-1:0]  pending_nx;
    logic [N_NEURONS-1:0]  gnt_oh;
    logic [N_NEURONS-1:0]  drop;
    logic [ADDR_W-1:0]     rr_ptr;
    logic [ADDR_W-1:0]     gnt;
    logic [ADDR_W-1:0]     idx;
    logic                  found;
    logic                  load;
    logic [DROP_W-1:0]     drop_cnt_nx;

    // Walk offsets downward so the smallest offset from rr_ptr wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = N_NEURONS - 1; off >= 0; off--) begin
            if (int'(rr_ptr) + off >= N_NEURONS)
                idx = ADDR_W'(int'(rr_ptr) + off - N_NEURONS);
            else
                idx = ADDR_W'(int'(rr_ptr) + off);
            if (pending[idx]) begin
                gnt   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    load     = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (aer_ready) begin
                    load     = found;
                    state_nx = found ? HOLD : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // A grant and a fresh spike on the same edge re-queue rather than drop.
    always_comb begin
        gnt_oh = '0;
        if (load)
            gnt_oh[gnt] = 1'b1;
        pending_nx = spike_in | (pending & ~gnt_oh);
        drop       = spike_in & pending & ~gnt_oh;
        drop_cnt_nx = drop_cnt;
        for (int i = 0; i < N_NEURONS; i++) begin
            if (drop[i] && drop_cnt_nx != '1)
                drop_cnt_nx = drop_cnt_nx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pending  <= '0;
            rr_ptr   <= '0;
            aer_addr <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state    <= state_nx;
            pending  <= pending_nx;
            overflow <= |drop;
            drop_cnt <= drop_cnt_nx;
            if (load) begin
                aer_addr <= gnt;
                if (gnt == ADDR_W'(N_NEURONS - 1))
                    rr_ptr <= '0;
                else
                    rr_ptr <= gnt + 1'b1;
            end
        end
    end

    assign aer_valid = (state == HOLD);

`ifdef AER_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] ts_q [N_NEURONS];

    // Dropped spikes keep the timestamp of the event already queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt <= '0;
            aer_ts <= '0;
            for (int i = 0; i < N_NEURONS; i++)
                ts_q[i] <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            for (int i = 0; i < N_NEURONS; i++) begin
                if (spike_in[i] && !drop[i])
                    ts_q[i] <= ts_cnt;
            end
            if (load)
                aer_ts <= ts_q[gnt];
        end
    end
`endif

endmodule
